// File: rtl/bit_serializer_pkg.sv
// Shared types and constants for the bit serializer slice.
package bit_ser_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

   localparam int unsigned DEFAULT_WIDTH = 8;

   // Counter width for 0..width-1, never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned width);
      return (width > 2) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/bit_serializer_if.sv
// Parallel-in / serial-out handshake bundle for bit_serializer.
interface bit_serializer_if
   import bit_ser_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
);

   logic [WIDTH-1:0] data_in;
   logic             data_valid;
   logic             data_ready;
   logic             msb_first;
   logic             ser_out;
   logic             ser_valid;
   logic             busy;

   modport master (
      output data_in,
      output data_valid,
      output msb_first,
      input  data_ready,
      input  ser_out,
      input  ser_valid,
      input  busy
   );

   modport slave (
      input  data_in,
      input  data_valid,
      input  msb_first,
      output data_ready,
      output ser_out,
      output ser_valid,
      output busy
   );

endinterface

// File: rtl/bit_serializer_shreg.sv
// Shift register, bit counter and bit-order select; ser_bit is always the register MSB.
module bit_ser_shreg
   import bit_ser_pkg::*;
#(
   parameter int unsigned WIDTH    = DEFAULT_WIDTH,
   parameter logic        IDLE_BIT = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] load_data,
   input  logic             load_msb_first,
   output logic             ser_bit,
   output logic             last_bit
);

   localparam int unsigned    CW       = cnt_width(WIDTH);
   localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

   logic [WIDTH-1:0] sreg_q;
   logic [WIDTH-1:0] sreg_d;
   logic [WIDTH-1:0] load_ordered;
   logic [CW-1:0]    bit_cnt_q;
   logic [CW-1:0]    bit_cnt_d;

   always_comb begin
      load_ordered = load_data;
      if (!load_msb_first) begin
         for (int unsigned i = 0; i < WIDTH; i++) begin
            load_ordered[i] = load_data[WIDTH-1-i];
         end
      end
   end

   // Shifting in IDLE_BIT means the register drains to the idle level by itself,
   // so ser_bit needs no output mux once the last bit has gone out.
   always_comb begin
      sreg_d    = sreg_q;
      bit_cnt_d = bit_cnt_q;
      if (load) begin
         sreg_d    = load_ordered;
         bit_cnt_d = '0;
      end else if (shift) begin
         sreg_d    = {sreg_q[WIDTH-2:0], IDLE_BIT};
         bit_cnt_d = (bit_cnt_q == LAST_CNT) ? '0 : bit_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sreg_q    <= {WIDTH{IDLE_BIT}};
         bit_cnt_q <= '0;
      end else begin
         sreg_q    <= sreg_d;
         bit_cnt_q <= bit_cnt_d;
      end
   end

   assign ser_bit  = sreg_q[WIDTH-1];
   assign last_bit = (bit_cnt_q == LAST_CNT);

endmodule

// File: rtl/bit_serializer.sv
// Word-to-bit-stream serializer: IDLE/SHIFT FSM with a one-word holding register.
module bit_serializer
   import bit_ser_pkg::*;
#(
   parameter int unsigned WIDTH    = DEFAULT_WIDTH,
   parameter logic        IDLE_BIT = 1'b0
) (
   input  logic                   clk,
   input  logic                   reset,
   bit_serializer_if.slave        bus
);

   state_e           state_q;
   state_e           state_d;
   logic [WIDTH-1:0] hold_q;
   logic [WIDTH-1:0] hold_d;
   logic             hold_msb_q;
   logic             hold_msb_d;
   logic             hold_full_q;
   logic             hold_full_d;
   logic             ser_valid_q;
   logic             ser_valid_d;
   logic             busy_q;
   logic             busy_d;
   logic             data_ready_q;
   logic             data_ready_d;

   logic             accept;
   logic             last_bit;
   logic             ser_bit;
   logic             sh_load;
   logic             sh_shift;
   logic [WIDTH-1:0] sh_data;
   logic             sh_msb_first;

   // data_ready_q mirrors !hold_full_q, so a transfer that frees the holding
   // register cannot also admit a new word on the same edge.
   assign accept = bus.data_valid && data_ready_q;

   always_comb begin
      state_d      = state_q;
      hold_d       = hold_q;
      hold_msb_d   = hold_msb_q;
      hold_full_d  = hold_full_q;
      sh_load      = 1'b0;
      sh_data      = bus.data_in;
      sh_msb_first = bus.msb_first;

      case (state_q)
         IDLE: begin
            if (accept) begin
               sh_load = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (last_bit) begin
               if (hold_full_q) begin
                  sh_load      = 1'b1;
                  sh_data      = hold_q;
                  sh_msb_first = hold_msb_q;
                  hold_d       = '0;
                  hold_full_d  = 1'b0;
               end else if (accept) begin
                  sh_load = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else if (accept) begin
               hold_d      = bus.data_in;
               hold_msb_d  = bus.msb_first;
               hold_full_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      sh_shift     = (state_q == SHIFT) && !sh_load;
      ser_valid_d  = (state_d == SHIFT);
      busy_d       = (state_d == SHIFT) || hold_full_d;
      data_ready_d = !hold_full_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         hold_q       <= '0;
         hold_msb_q   <= 1'b0;
         hold_full_q  <= 1'b0;
         ser_valid_q  <= 1'b0;
         busy_q       <= 1'b0;
         data_ready_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         hold_q       <= hold_d;
         hold_msb_q   <= hold_msb_d;
         hold_full_q  <= hold_full_d;
         ser_valid_q  <= ser_valid_d;
         busy_q       <= busy_d;
         data_ready_q <= data_ready_d;
      end
   end

   bit_ser_shreg #(
      .WIDTH    (WIDTH),
      .IDLE_BIT (IDLE_BIT)
   ) u_shreg (
      .clk            (clk),
      .reset          (reset),
      .load           (sh_load),
      .shift          (sh_shift),
      .load_data      (sh_data),
      .load_msb_first (sh_msb_first),
      .ser_bit        (ser_bit),
      .last_bit       (last_bit)
   );

   assign bus.ser_out    = ser_bit;
   assign bus.ser_valid  = ser_valid_q;
   assign bus.busy       = busy_q;
   assign bus.data_ready = data_ready_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: two instances, IDLE_BIT = 0 and IDLE_BIT = 1.
module tb_bit_serializer;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   bit_serializer_if #(.WIDTH(8)) bus0 ();
   bit_serializer_if #(.WIDTH(8)) bus1 ();

   bit_serializer #(.WIDTH(8), .IDLE_BIT(1'b0)) dut0 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus0)
   );

   bit_serializer #(.WIDTH(8), .IDLE_BIT(1'b1)) dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus1)
   );

   // Pattern counter for 1101 on the valid bits of dut0
   logic [3:0] det_hist;
   int         det_cnt;
   logic       det_clr;

   always @(posedge clk) begin
      if (det_clr) begin
         det_hist <= '0;
         det_cnt  <= 0;
      end else if (bus0.ser_valid) begin
         det_hist <= {det_hist[2:0], bus0.ser_out};
         if ({det_hist[2:0], bus0.ser_out} == 4'b1101) det_cnt <= det_cnt + 1;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // exp_bits[7] is the first bit expected on ser_out.
   task automatic run_word(input string tag, input logic [7:0] w, input logic msb,
                           input logic [7:0] exp_bits);
      bus0.data_in    = w;
      bus0.msb_first  = msb;
      bus0.data_valid = 1'b1;
      check_bit({tag, "_ready"}, bus0.data_ready, 1'b1);
      step();
      bus0.data_valid = 1'b0;
      bus0.data_in    = 8'h00;
      bus0.msb_first  = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check_bit($sformatf("%s_valid%0d", tag, i), bus0.ser_valid, 1'b1);
         check_bit($sformatf("%s_bit%0d", tag, i), bus0.ser_out, exp_bits[7-i]);
         step();
      end
      check_bit({tag, "_valid_end"}, bus0.ser_valid, 1'b0);
      check_bit({tag, "_out_end"}, bus0.ser_out, 1'b0);
      check_bit({tag, "_busy_end"}, bus0.busy, 1'b0);
   endtask

   initial begin
      logic [15:0] s3;
      logic [23:0] s4;
      logic        exp_rdy;

      reset           = 1'b1;
      det_clr         = 1'b1;
      bus0.data_in    = 8'h00;
      bus0.data_valid = 1'b0;
      bus0.msb_first  = 1'b0;
      bus1.data_in    = 8'h00;
      bus1.data_valid = 1'b0;
      bus1.msb_first  = 1'b0;
      step();
      step();

      check_bit("rst_ser_out", bus0.ser_out, 1'b0);
      check_bit("rst_ser_valid", bus0.ser_valid, 1'b0);
      check_bit("rst_data_ready", bus0.data_ready, 1'b1);
      check_bit("rst_busy", bus0.busy, 1'b0);
      check_bit("rst_idle1_out", bus1.ser_out, 1'b1);

      reset = 1'b0;
      step();
      det_clr = 1'b0;

      // Single word, MSB first
      run_word("d0_msb", 8'hD0, 1'b1, 8'b1101_0000);
      check_int("d0_detect", det_cnt, 1);

      det_clr = 1'b1;
      step();
      det_clr = 1'b0;

      // Single word, LSB first: identical stream
      run_word("0b_lsb", 8'h0B, 1'b0, 8'b1101_0000);
      check_int("0b_detect", det_cnt, 1);

      // Back-to-back DD then B6
      s3              = 16'hDDB6;
      bus0.data_in    = 8'hDD;
      bus0.msb_first  = 1'b1;
      bus0.data_valid = 1'b1;
      step();
      for (int c = 1; c <= 16; c++) begin
         if (c == 1) bus0.data_in = 8'hB6;
         if (c == 2) bus0.data_valid = 1'b0;
         exp_rdy = (c == 1) || (c > 8);
         check_bit($sformatf("b2b_valid%0d", c), bus0.ser_valid, 1'b1);
         check_bit($sformatf("b2b_bit%0d", c), bus0.ser_out, s3[16-c]);
         check_bit($sformatf("b2b_ready%0d", c), bus0.data_ready, exp_rdy);
         step();
      end
      check_bit("b2b_valid_end", bus0.ser_valid, 1'b0);
      check_bit("b2b_busy_end", bus0.busy, 1'b0);

      // Three words offered continuously: 81 msb, 3C msb, 4E lsb
      s4              = 24'h813C72;
      bus0.data_in    = 8'h81;
      bus0.msb_first  = 1'b1;
      bus0.data_valid = 1'b1;
      step();
      for (int c = 1; c <= 24; c++) begin
         if (c == 1) bus0.data_in = 8'h3C;
         if (c == 2) begin
            bus0.data_in   = 8'h4E;
            bus0.msb_first = 1'b0;
         end
         if (c == 10) bus0.data_valid = 1'b0;
         exp_rdy = (c == 1) || (c == 9) || (c >= 17);
         check_bit($sformatf("three_valid%0d", c), bus0.ser_valid, 1'b1);
         check_bit($sformatf("three_bit%0d", c), bus0.ser_out, s4[24-c]);
         check_bit($sformatf("three_ready%0d", c), bus0.data_ready, exp_rdy);
         check_bit($sformatf("three_busy%0d", c), bus0.busy, 1'b1);
         step();
      end
      check_bit("three_valid_end", bus0.ser_valid, 1'b0);
      check_bit("three_busy_end", bus0.busy, 1'b0);

      // Reset during bit 4 of FF with 55 held, accept offered at the same edge
      bus0.data_in    = 8'hFF;
      bus0.msb_first  = 1'b1;
      bus0.data_valid = 1'b1;
      step();
      bus0.data_in = 8'h55;
      step();
      bus0.data_valid = 1'b0;
      check_bit("mid_hold_ready", bus0.data_ready, 1'b0);
      step();
      step();
      step();
      check_bit("mid_bit4_valid", bus0.ser_valid, 1'b1);
      check_bit("mid_bit4_out", bus0.ser_out, 1'b1);
      reset           = 1'b1;
      bus0.data_in    = 8'h3C;
      bus0.data_valid = 1'b1;
      step();
      reset           = 1'b0;
      bus0.data_valid = 1'b0;
      check_bit("mid_rst_valid", bus0.ser_valid, 1'b0);
      check_bit("mid_rst_busy", bus0.busy, 1'b0);
      check_bit("mid_rst_ready", bus0.data_ready, 1'b1);
      check_bit("mid_rst_out", bus0.ser_out, 1'b0);
      for (int c = 0; c < 10; c++) begin
         step();
         check_bit($sformatf("mid_quiet%0d", c), bus0.ser_valid, 1'b0);
      end
      run_word("a5_after_rst", 8'hA5, 1'b1, 8'b1010_0101);

      // IDLE_BIT = 1 instance left idle
      for (int c = 0; c < 10; c++) begin
         check_bit($sformatf("idle1_out%0d", c), bus1.ser_out, 1'b1);
         check_bit($sformatf("idle1_valid%0d", c), bus1.ser_valid, 1'b0);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning parallel word width in bits (legal range 2..32).
REQ-002 SHALL have parameter IDLE_BIT, default 1'b0, meaning the value driven on ser_out while no word is being shifted.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port data_in  input  WIDTH  parallel word to serialize.
REQ-006 SHALL have port data_valid  input  1  data_in holds a valid word.
REQ-007 SHALL have port data_ready  output  1  block can accept a word this cycle.
REQ-008 SHALL have port msb_first  input  1  bit order for the word accepted this cycle (1 = MSB first).
REQ-009 SHALL have port ser_out  output  1  serial bit stream; drives the sequence detector's in.
REQ-010 SHALL have port ser_valid  output  1  ser_out carries a word bit this cycle.
REQ-011 SHALL have port busy  output  1  shift register or holding register is occupied.

Function
REQ-012 SHALL transfer a word only on a rising edge where data_valid && data_ready are both high; msb_first is captured with the word.
REQ-013 SHALL hold two entries: a shift register plus a one-word holding register. data_ready SHALL equal !hold_full.
REQ-014 SHALL implement FSM states IDLE and SHIFT, held in registers: IDLE->SHIFT on accept; SHIFT->SHIFT on the last bit if a next word is available; SHIFT->IDLE on the last bit otherwise.
REQ-015 SHALL route an accept in IDLE directly into the shift register, and an accept in SHIFT into the holding register. Exception: an accept on the last-bit cycle with the holding register empty SHALL bypass into the shift register.
REQ-016 SHALL present the first bit of an accepted word on ser_out one cycle after the accept edge (latency 1), and then one bit per cycle for exactly WIDTH consecutive cycles.
REQ-017 SHALL hold ser_valid high for each of those WIDTH cycles.
REQ-018 SHALL maintain bit counter bit_cnt, width clog2(WIDTH), counting 0..WIDTH-1. The last bit is bit_cnt == WIDTH-1, after which bit_cnt wraps to 0.
REQ-019 SHALL, on the last bit with the holding register full, move the holding word into the shift register and free the holding register. The next word's first bit SHALL follow with no gap cycle.
REQ-020 SHALL not accept a word on a cycle where the holding register is full at the edge. data_ready stays low that cycle, even if a transfer frees the holding register at the same edge.
REQ-021 SHALL drive ser_out = IDLE_BIT and ser_valid = 0 whenever in IDLE.
REQ-022 SHALL set busy = (state == SHIFT) || hold_full.
REQ-023 SHALL ignore data_in and msb_first when no accept occurs.

Reset
REQ-024 SHALL, on a reset edge, set state = IDLE, bit_cnt = 0, hold_full = 0, clear the shift and holding registers, and set outputs to ser_out = IDLE_BIT, ser_valid = 0, data_ready = 1, busy = 0.
REQ-025 SHALL, on reset mid-word, discard both the in-flight word and the held word with no further ser_valid pulses. Reset SHALL take priority over a simultaneous accept.

Structure
REQ-026 SHALL place the state enum typedef (IDLE, SHIFT) and the default WIDTH constant in the shared package bit_ser_pkg.
REQ-027 SHALL implement the shift register, bit counter and order-select logic as one sub-module, bit_ser_shreg, instantiated once. The FSM and holding register SHALL live in the top module.

Verification
REQ-028 SHALL cover: single word 8'hD0, msb_first = 1 -> ser_out 1,1,0,1,0,0,0,0 on cycles 1..8 after accept; ser_valid high for exactly those 8 cycles; detector flags 1101 once.
REQ-029 SHALL cover: single word 8'h0B, msb_first = 0 -> ser_out 1,1,0,1,0,0,0,0; identical stream to REQ-028.
REQ-030 SHALL cover: back-to-back 8'hDD then 8'hB6, data_valid held high -> 16 contiguous ser_valid cycles with no gap; data_ready low from the cycle after the second accept until the first word's last bit.
REQ-031 SHALL cover: three words offered continuously -> third word stalled (data_ready = 0) until the hold-to-shift transfer, then accepted; 24 contiguous bits total.
REQ-032 SHALL cover: reset asserted during bit 4 of 8'hFF with a word held -> next cycle ser_valid = 0, busy = 0, data_ready = 1; a following 8'hA5 serializes cleanly from its first bit.
REQ-033 SHALL cover: idle with IDLE_BIT = 1 for 10 cycles -> ser_out = 1 and ser_valid = 0 throughout.
